// File: rtl/minmax_pkg.sv
// Shared types for the min/max frame reducer: FSM state encoding and the
// polarity of the mode-select bits.
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_MIN     = 1'b0;
  localparam logic MODE_MAX     = 1'b1;
  localparam logic CMP_UNSIGNED = 1'b0;
  localparam logic CMP_SIGNED   = 1'b1;

endpackage

// File: rtl/cmp_int_nbit.sv
// Magnitude comparator: a > b and a == b, in either two's-complement or
// unsigned interpretation selected at run time.
module cmp_int_nbit #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             gt,
  output logic             eq
);

  // One extra bit: sign-extend in signed mode, zero-extend otherwise, then a
  // single signed compare covers both interpretations.
  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;

  assign a_ext = {is_signed & a[WIDTH-1], a};
  assign b_ext = {is_signed & b[WIDTH-1], b};
  assign gt    = (a_ext > b_ext);
  assign eq    = (a == b);

endmodule

// File: rtl/minmax_reduce_int.sv
// Streams a frame of integers and reports its minimum or maximum, the
// zero-based position of that element and the frame length.
module minmax_reduce_int
  import minmax_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int MAX_LEN = 16,
  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_max,
  input  logic             mode_signed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] out_count
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             mode_max_q;
  logic             mode_signed_q;
  logic             accept;
  logic             gt;
  logic             eq;
  logic             better;
  logic             final_beat;

  assign accept = in_valid && in_ready;

  cmp_int_nbit #(.WIDTH(WIDTH)) u_cmp (
    .a         (in_data),
    .b         (acc),
    .is_signed (mode_signed_q),
    .gt        (gt),
    .eq        (eq)
  );

  // Strict comparison in both directions so ties keep the earlier element.
  assign better = (mode_max_q == MODE_MAX) ? gt : (!gt && !eq);

  always_comb begin
    final_beat = in_last;
    if (state == IDLE) begin
      final_beat = in_last || (MAX_LEN == 1);
    end else if (state == ACCUM) begin
      final_beat = in_last || (cnt == CNT_W'(MAX_LEN - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = final_beat ? DONE : ACCUM;
      end
      ACCUM: begin
        if (accept && final_beat) state_nx = DONE;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Running extremum, its index, element count and the modes latched on the
  // first beat; cnt doubles as the index of the element being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      idx           <= '0;
      cnt           <= '0;
      mode_max_q    <= MODE_MIN;
      mode_signed_q <= CMP_UNSIGNED;
    end else if (accept) begin
      case (state)
        IDLE: begin
          acc           <= in_data;
          idx           <= '0;
          cnt           <= CNT_W'(1);
          mode_max_q    <= mode_max;
          mode_signed_q <= mode_signed;
        end
        ACCUM: begin
          cnt <= cnt + 1'b1;
          if (better) begin
            acc <= in_data;
            idx <= IDX_W'(cnt);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = acc;
  assign out_index = idx;
  assign out_count = cnt;

endmodule

// File: tb/tb_minmax_reduce_int.sv
// Directed bench for minmax_reduce_int at WIDTH=8, MAX_LEN=4.
module tb_minmax_reduce_int;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mode_max = 1'b0;
  logic       mode_signed = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_index;
  logic [2:0] out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minmax_reduce_int #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_max    (mode_max),
    .mode_signed (mode_signed),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_count   (out_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [7:0] d,
                               input logic [1:0] idx, input logic [2:0] cnt);
    check({tag, "_vld"},   32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_index"}, 32'(out_index), 32'(idx));
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    check({tag, "_rdy"},   32'(in_ready),  32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drain_vld"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_rdy"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vld",   32'(out_valid), 32'd0);
    check("rst_rdy",   32'(in_ready),  32'd1);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 32'(in_ready), 32'd1);

    // Signed minimum with a tie on -3
    mode_max = 1'b0; mode_signed = 1'b1;
    send(8'h05, 1'b0); send(8'hFD, 1'b0); send(8'h07, 1'b0); send(8'hFD, 1'b1);
    expect_result("smin", 8'hFD, 2'd1, 3'd4);

    // Unsigned maximum, same data
    mode_max = 1'b1; mode_signed = 1'b0;
    send(8'h05, 1'b0); send(8'hFD, 1'b0); send(8'h07, 1'b0); send(8'hFD, 1'b1);
    expect_result("umax", 8'hFD, 2'd1, 3'd4);

    // Signed maximum, same data
    mode_max = 1'b1; mode_signed = 1'b1;
    send(8'h05, 1'b0); send(8'hFD, 1'b0); send(8'h07, 1'b0); send(8'hFD, 1'b1);
    expect_result("smax", 8'h07, 2'd2, 3'd4);

    // Forced termination at MAX_LEN; fifth beat stalls and opens next frame
    mode_max = 1'b1; mode_signed = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    in_valid = 1'b1; in_data = 8'h09; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("force_vld",   32'(out_valid), 32'd1);
      check("force_rdy",   32'(in_ready),  32'd0);
      check("force_data",  32'(out_data),  32'h04);
      check("force_index", 32'(out_index), 32'd3);
      check("force_count", 32'(out_count), 32'd4);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("force_idle_vld", 32'(out_valid), 32'd0);
    check("force_idle_rdy", 32'(in_ready),  32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("force_next_vld", 32'(out_valid), 32'd0);
    send(8'h02, 1'b1);
    expect_result("force_next", 8'h09, 2'd0, 3'd2);

    // Single element frame
    mode_max = 1'b0; mode_signed = 1'b1;
    send(8'h80, 1'b1);
    expect_result("single", 8'h80, 2'd0, 3'd1);

    // Mode toggled mid-frame, idle gap, then output held under backpressure
    mode_max = 1'b1; mode_signed = 1'b1;
    send(8'h10, 1'b0);
    mode_max = 1'b0; mode_signed = 1'b0;
    repeat (2) @(negedge clk);
    check("gap_vld",   32'(out_valid), 32'd0);
    check("gap_count", 32'(out_count), 32'd1);
    send(8'hF0, 1'b0); send(8'h30, 1'b1);
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("hold_vld",   32'(out_valid), 32'd1);
      check("hold_rdy",   32'(in_ready),  32'd0);
      check("hold_data",  32'(out_data),  32'h30);
      check("hold_index", 32'(out_index), 32'd2);
      check("hold_count", 32'(out_count), 32'd3);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    expect_result("toggle", 8'h30, 2'd2, 3'd3);

    // Reset mid-frame discards the partial frame
    mode_max = 1'b0; mode_signed = 1'b1;
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_vld", 32'(out_valid), 32'd0);
      check("midrst_rdy", 32'(in_ready),  32'd1);
    end
    check("midrst_count", 32'(out_count), 32'd0);
    mode_max = 1'b0; mode_signed = 1'b0;
    send(8'h40, 1'b0); send(8'h20, 1'b1);
    expect_result("after_rst", 8'h20, 2'd1, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
